// File: rtl/i2c_master_byte_if.sv
// Request, open-drain line control and status bundle for i2c_master_byte.
// The master modport is the engine's view; the slave modport is the requester/bus side.
interface i2c_master_byte_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       sda_i;
    logic       scl_i;
    logic       sda_oe;
    logic       scl_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

    modport master (
        input  start, rw, addr, wdata, sda_i, scl_i,
        output sda_oe, scl_oe, busy, done, ack_err, rdata
    );

    modport slave (
        output start, rw, addr, wdata, sda_i, scl_i,
        input  sda_oe, scl_oe, busy, done, ack_err, rdata
    );
endinterface

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP; 4 i2c_clk phases per bus bit.
// Optional slave clock stretching with timeout is enabled by defining I2C_MASTER_CLK_STRETCH_EN.
module i2c_master_byte #(
    parameter int BUS_FREE_CYCLES = 4,
    parameter int STRETCH_TIMEOUT = 255
) (
    input  logic              i2c_clk,
    input  logic              reset,
    i2c_master_byte_if.master bus
);
    localparam int FREE_W = (BUS_FREE_CYCLES > 0) ? $clog2(BUS_FREE_CYCLES + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, STOP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          addr_byte_q, addr_byte_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rx_q, rx_d;
    logic [FREE_W-1:0]   free_q, free_d;
    logic                sda_oe_q, sda_oe_d;
    logic                scl_oe_q, scl_oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ack_err_q, ack_err_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                tx_next;
    logic                stretch_hold;
    logic                stretch_timeout;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    localparam int STRETCH_W = $clog2(STRETCH_TIMEOUT + 1);

    logic [STRETCH_W-1:0] stretch_q, stretch_d;

    // p1 is held while the slave keeps SCL low; the counter clears whenever p1 is not being held.
    always_comb begin
        stretch_d       = '0;
        stretch_hold    = 1'b0;
        stretch_timeout = 1'b0;
        if (state_q != IDLE && phase_q == 2'd1 && !bus.scl_i) begin
            if (stretch_q == STRETCH_W'(STRETCH_TIMEOUT)) begin
                stretch_timeout = 1'b1;
            end else begin
                stretch_hold = 1'b1;
                stretch_d    = stretch_q + STRETCH_W'(1);
            end
        end
    end

    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            stretch_q <= '0;
        end else begin
            stretch_q <= stretch_d;
        end
    end
`else
    logic unused_stretch;

    assign stretch_hold    = 1'b0;
    assign stretch_timeout = 1'b0;
    assign unused_stretch  = bus.scl_i & (STRETCH_TIMEOUT > 0);
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        addr_byte_d = addr_byte_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        free_d      = free_q;
        ack_err_d   = ack_err_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;

        if (state_q == IDLE) begin
            phase_d = 2'd0;
            bit_d   = 3'd0;
            if (free_q != '0) begin
                free_d = free_q - FREE_W'(1);
            end else if (bus.start) begin
                state_d     = START;
                addr_byte_d = {bus.addr, bus.rw};
                wdata_d     = bus.wdata;
                ack_err_d   = 1'b0;
            end
        end else if (stretch_timeout) begin
            state_d   = IDLE;
            phase_d   = 2'd0;
            ack_err_d = 1'b1;
            done_d    = 1'b1;
            free_d    = FREE_W'(BUS_FREE_CYCLES);
        end else if (!stretch_hold) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd2) begin
                case (state_q)
                    ADDR_ACK, WR_ACK: if (bus.sda_i) ack_err_d = 1'b1;
                    RD:               rx_d = {rx_q[6:0], bus.sda_i};
                    default:          ;
                endcase
            end
            // Bit boundaries: bit_q wraps 7 -> 0 on its own, so it is ready for the next byte.
            if (phase_q == 2'd3) begin
                case (state_q)
                    START: state_d = ADDR;
                    ADDR: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = ADDR_ACK;
                    end
                    ADDR_ACK: begin
                        if (ack_err_q)           state_d = STOP;
                        else if (addr_byte_q[0]) state_d = RD;
                        else                     state_d = WR;
                    end
                    WR: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = WR_ACK;
                    end
                    WR_ACK: state_d = STOP;
                    RD: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = RD_ACK;
                    end
                    RD_ACK: state_d = STOP;
                    STOP: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        free_d  = FREE_W'(BUS_FREE_CYCLES);
                        if (addr_byte_q[0] && !ack_err_q) rdata_d = rx_q;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Line enables are decoded from the next state/phase so they register in step with the FSM.
    always_comb begin
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
        tx_next  = (state_d == ADDR) ? addr_byte_d[~bit_d] : wdata_d[~bit_d];
        case (state_d)
            START: begin
                sda_oe_d = phase_d[1];
                scl_oe_d = (phase_d == 2'd3);
            end
            ADDR, WR: begin
                sda_oe_d = ~tx_next;
                scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
            end
            ADDR_ACK, WR_ACK, RD, RD_ACK: begin
                scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
            end
            STOP: begin
                sda_oe_d = (phase_d <= 2'd1);
                scl_oe_d = (phase_d == 2'd0);
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            bit_q       <= 3'd0;
            addr_byte_q <= 8'h00;
            wdata_q     <= 8'h00;
            rx_q        <= 8'h00;
            free_q      <= '0;
            sda_oe_q    <= 1'b0;
            scl_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            addr_byte_q <= addr_byte_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            free_q      <= free_d;
            sda_oe_q    <= sda_oe_d;
            scl_oe_q    <= scl_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.sda_oe  = sda_oe_q;
    assign bus.scl_oe  = scl_oe_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: cycle-indexed slave model with scoreboards for driven SDA bits and results.
// Define I2C_MASTER_CLK_STRETCH_EN to also exercise slave clock stretching.
`timescale 1ns/1ps
module tb_i2c_master_byte;
    localparam int BUS_FREE = 4;

    typedef struct {
        int         lat;
        logic       ack_err;
        logic [7:0] rdata;
    } result_t;

    logic       i2c_clk = 1'b0;
    logic       reset;
    logic       slave_low;
    logic       stretch_low;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       exp_bits[$];
    result_t    exp_res[$];
    logic [7:0] last_rdata;

    i2c_master_byte_if bus ();

    i2c_master_byte #(
        .BUS_FREE_CYCLES(BUS_FREE),
        .STRETCH_TIMEOUT(255)
    ) dut (
        .i2c_clk(i2c_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 i2c_clk = ~i2c_clk;

    // Open-drain wired-AND: a line reads high only when nobody pulls it low.
    assign bus.sda_i = ~(bus.sda_oe | slave_low);
    assign bus.scl_i = ~(bus.scl_oe | stretch_low);

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Runs one transaction from a negedge where start may be accepted; returns at the negedge after done.
    task automatic do_txn(input string name, input logic t_rw, input logic [6:0] t_addr,
                          input logic [7:0] t_wdata, input logic [7:0] t_slave,
                          input logic t_addr_nack, input logic t_data_nack,
                          input bit inject_mid, input int stretch_len);
        logic [7:0] abyte;
        logic       bexp;
        logic       data_wr;
        result_t    r;
        result_t    got;
        int         k;
        int         j;
        int         lat;
        int         base;
        bit         seen;

        abyte   = {t_addr, t_rw};
        data_wr = !t_rw && !t_addr_nack;
        for (int b = 7; b >= 0; b--) exp_bits.push_back(abyte[b]);
        if (data_wr) for (int b = 7; b >= 0; b--) exp_bits.push_back(t_wdata[b]);
        base      = t_addr_nack ? 44 : 80;
        r.lat     = base + stretch_len;
        r.ack_err = t_addr_nack | (data_wr & t_data_nack);
        r.rdata   = (t_rw && !t_addr_nack) ? t_slave : last_rdata;
        last_rdata = r.rdata;
        exp_res.push_back(r);

        bus.rw    = t_rw;
        bus.addr  = t_addr;
        bus.wdata = t_wdata;
        bus.start = 1'b1;
        @(negedge i2c_clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s busy_after_accept: got %b want 1", name, bus.busy);
        end

        k    = 0;
        lat  = -1;
        seen = 1'b0;
        while (!seen && k < 600) begin
            if (stretch_len > 0 && k == 4) stretch_low = 1'b1;
            if (stretch_len > 0 && k == 5 + stretch_len) stretch_low = 1'b0;
            if (k <= 5) j = k;
            else if (k <= 5 + stretch_len) j = 5;
            else j = k - stretch_len;
            if (inject_mid && k == 10) begin
                bus.start = 1'b1;
                bus.rw    = ~t_rw;
                bus.addr  = ~t_addr;
                bus.wdata = ~t_wdata;
            end
            if (inject_mid && k == 11) bus.start = 1'b0;

            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                if ((j % 4 == 2) && ((j >= 4 && j < 36) || (data_wr && j >= 40 && j < 72))) begin
                    n_cmp++;
                    if (exp_bits.size() == 0) begin
                        n_bad++;
                        $display("[TB] FAIL %s sda_bit@%0d: got %b want nothing queued", name, j, bus.sda_i);
                    end else begin
                        bexp = exp_bits.pop_front();
                        if (bus.sda_i !== bexp) begin
                            n_bad++;
                            $display("[TB] FAIL %s sda_bit@%0d: got %b want %b", name, j, bus.sda_i, bexp);
                        end
                    end
                end
                if (j == 2 || j == base - 3 || j == base - 2 || j == 12 || j == 13) begin
                    logic [1:0] want;
                    if (j == 2)              want = 2'b10;
                    else if (j == base - 3)  want = 2'b10;
                    else if (j == base - 2)  want = 2'b00;
                    else if (j == 12)        want = {~abyte[5], 1'b1};
                    else                     want = {~abyte[5], 1'b0};
                    n_cmp++;
                    if ({bus.sda_oe, bus.scl_oe} !== want) begin
                        n_bad++;
                        $display("[TB] FAIL %s lines@%0d: got sda_oe,scl_oe=%b want %b", name, j,
                                 {bus.sda_oe, bus.scl_oe}, want);
                    end
                end
                if (t_rw && !t_addr_nack && j == 74) begin
                    n_cmp++;
                    if (bus.sda_oe !== 1'b0) begin
                        n_bad++;
                        $display("[TB] FAIL %s rd_nack_release: got sda_oe=%b want 0", name, bus.sda_oe);
                    end
                end
                if (j == base - 1) begin
                    n_cmp++;
                    if (bus.busy !== 1'b1) begin
                        n_bad++;
                        $display("[TB] FAIL %s busy_in_stop: got %b want 1", name, bus.busy);
                    end
                end

                slave_low = 1'b0;
                if (j >= 36 && j <= 39) slave_low = !t_addr_nack;
                else if (!t_addr_nack && t_rw && j >= 40 && j <= 71) slave_low = !t_slave[7 - (j - 40) / 4];
                else if (data_wr && j >= 72 && j <= 75) slave_low = !t_data_nack;

                @(negedge i2c_clk);
                k++;
            end
        end
        slave_low = 1'b0;

        got = exp_res.pop_front();
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL %s done_timeout: got no done in %0d cycles want done at %0d", name, k, got.lat);
        end else begin
            if (lat != got.lat) begin
                n_bad++;
                $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, got.lat);
            end
            n_cmp++;
            if (bus.ack_err !== got.ack_err) begin
                n_bad++;
                $display("[TB] FAIL %s ack_err: got %b want %b", name, bus.ack_err, got.ack_err);
            end
            n_cmp++;
            if (bus.rdata !== got.rdata) begin
                n_bad++;
                $display("[TB] FAIL %s rdata: got %h want %h", name, bus.rdata, got.rdata);
            end
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL %s busy_at_done: got %b want 0", name, bus.busy);
            end
        end
        n_cmp++;
        if (exp_bits.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL %s bits_left: got %0d unsent want 0", name, exp_bits.size());
            exp_bits.delete();
        end
        @(negedge i2c_clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL %s done_pulse_width: got %b want 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.addr  = 7'h50;
        repeat (3) @(negedge i2c_clk);
        n_cmp++;
        if ({bus.sda_oe, bus.scl_oe, bus.busy, bus.done, bus.ack_err} !== 5'b00000) begin
            n_bad++;
            $display("[TB] FAIL reset_flags: got %b want 00000",
                     {bus.sda_oe, bus.scl_oe, bus.busy, bus.done, bus.ack_err});
        end
        n_cmp++;
        if (bus.rdata !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL reset_rdata: got %h want 00", bus.rdata);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge i2c_clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_wins_over_start: got busy=%b want 0", bus.busy);
        end
        repeat (2) @(negedge i2c_clk);
    endtask

    task automatic test_write();
        do_txn("write", 1'b0, 7'h50, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge i2c_clk);
    endtask

    task automatic test_read();
        do_txn("read", 1'b1, 7'h3C, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge i2c_clk);
    endtask

    task automatic test_addr_nack();
        do_txn("addr_nack", 1'b0, 7'h11, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) @(negedge i2c_clk);
    endtask

    task automatic test_data_nack();
        do_txn("data_nack", 1'b0, 7'h20, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 0);
        repeat (3) @(negedge i2c_clk);
    endtask

    // Start during busy (cycle 10) and inside the bus-free window (2 after done) must both be ignored.
    task automatic test_back_to_back();
        do_txn("b2b_first", 1'b0, 7'h2A, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        @(negedge i2c_clk);
        bus.rw    = 1'b0;
        bus.addr  = 7'h01;
        bus.start = 1'b1;
        @(negedge i2c_clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL bus_free_ignore: got busy=%b want 0", bus.busy);
        end
        @(negedge i2c_clk);
        do_txn("b2b_second", 1'b1, 7'h3C, 8'h00, 8'h96, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge i2c_clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.rw    = 1'b0;
        bus.addr  = 7'h50;
        bus.wdata = 8'hA5;
        bus.start = 1'b1;
        @(negedge i2c_clk);
        bus.start = 1'b0;
        repeat (17) @(negedge i2c_clk);
        n_cmp++;
        if (bus.sda_oe !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_pre_sda: got %b want 1", bus.sda_oe);
        end
        reset = 1'b1;
        @(negedge i2c_clk);
        reset      = 1'b0;
        last_rdata = 8'h00;
        n_cmp++;
        if ({bus.sda_oe, bus.scl_oe, bus.busy, bus.done} !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_release: got %b want 0000",
                     {bus.sda_oe, bus.scl_oe, bus.busy, bus.done});
        end
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i2c_clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_no_done: got activity after reset want none");
        end
    endtask

`ifdef I2C_MASTER_CLK_STRETCH_EN
    task automatic test_stretch();
        do_txn("stretch", 1'b0, 7'h50, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 20);
        repeat (3) @(negedge i2c_clk);
    endtask

    task automatic test_stretch_timeout();
        bit seen;
        int k;
        bus.rw    = 1'b0;
        bus.addr  = 7'h50;
        bus.wdata = 8'hA5;
        bus.start = 1'b1;
        @(negedge i2c_clk);
        bus.start = 1'b0;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 300) begin
            if (k == 4) stretch_low = 1'b1;
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                @(negedge i2c_clk);
                k++;
            end
        end
        n_cmp++;
        if (!seen || k < 256) begin
            n_bad++;
            $display("[TB] FAIL stretch_timeout_done: got done=%b at %0d want done after 256", seen, k);
        end
        n_cmp++;
        if ({bus.ack_err, bus.sda_oe, bus.scl_oe} !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL stretch_timeout_state: got ack_err,sda_oe,scl_oe=%b want 100",
                     {bus.ack_err, bus.sda_oe, bus.scl_oe});
        end
        stretch_low = 1'b0;
        repeat (4) @(negedge i2c_clk);
    endtask
`endif

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.rw      = 1'b0;
        bus.addr    = 7'h00;
        bus.wdata   = 8'h00;
        slave_low   = 1'b0;
        stretch_low = 1'b0;
        last_rdata  = 8'h00;
        @(negedge i2c_clk);
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_MASTER_CLK_STRETCH_EN
        test_stretch();
        test_stretch_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
- Single-byte I2C master engine sitting directly downstream of the I2C clock divider.
- Clocked by the divided i2c_clk (100 kHz from 100 MHz ref_clk). Drives open-drain SCL/SDA enables.
- Executes one transaction per request: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
- Each bus bit occupies 4 i2c_clk cycles (phases p0..p3), so SCL = i2c_clk/4 (25 kHz).

Parameters:
- BUS_FREE_CYCLES, 4: minimum i2c_clk cycles spent in IDLE after STOP before a new start is accepted.
- STRETCH_TIMEOUT, 255: maximum cycles to wait for a released SCL to read high; used only with the optional feature.

Ports:
- i2c_clk  in  1  sole clock; all logic updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0 and the bus-free count has expired.
- rw  in  1  0 = write, 1 = read; captured with start.
- addr  in  7  slave address; captured with start.
- wdata  in  8  write byte; captured with start.
- sda_i  in  1  SDA line level.
- scl_i  in  1  SCL line level; used only with the optional feature.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- busy  out  1  high from the cycle after start is accepted through the end of STOP.
- done  out  1  one-cycle pulse at transaction end.
- ack_err  out  1  set when a slave NACK is seen; cleared on the next accepted start.
- rdata  out  8  byte received; valid when done pulses after a read.

Behaviour:
- All outputs are registered.
- Reset values: sda_oe=0, scl_oe=0, busy=0, done=0, ack_err=0, rdata=0. State=IDLE, phase=0, bus-free counter loaded as expired.
- States: IDLE, START, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, STOP.
- Every non-IDLE state steps through phases p0..p3, one cycle each.
- Bit phases:
  - p0: scl_oe=1, new SDA value driven.
  - p1, p2: scl_oe=0.
  - sda_i is sampled at the end of p2.
  - p3: scl_oe=1.
- START: p0/p1 SCL and SDA released; p2 sda_oe=1 (SDA falls while SCL is high); p3 scl_oe=1.
- ADDR: 8 bits, MSB first ({addr, rw}). sda_oe = ~bit.
- ADDR_ACK: SDA released; sample at p2.
  - sda_i=1: ack_err=1, go to STOP.
  - Else go to WR (rw=0) or RD (rw=1).
- WR: 8 bits of wdata, MSB first. WR_ACK: sample; sda_i=1 sets ack_err. Always then go to STOP.
- RD: SDA released; sda_i shifted into a register MSB first at each p2. RD_ACK: master sends NACK (SDA released) for the single byte.
- STOP: p0 scl_oe=1, sda_oe=1; p1 SCL released; p2 SDA released (rising while SCL is high); p3 hold.
- After STOP p3: done=1 for one cycle, busy=0, rdata updated (read only), bus-free counter restarts.
- Latency from start sample to done:
  - 80 cycles for a full transaction (4 + 32 + 4 + 32 + 4 + 4).
  - 44 cycles on address NACK.
- Start while busy=1, or before BUS_FREE_CYCLES have elapsed: ignored, no queuing.
- Inputs rw/addr/wdata are captured at accept; later changes have no effect.
- Reset mid-transaction: on the next edge both lines are released, busy=0, no STOP is generated, done is not pulsed.
- start and reset asserted together: reset wins.

Optional Feature:
- Macro: I2C_MASTER_CLK_STRETCH_EN.
- Defined:
  - At p1 of every bit (including START/STOP), the FSM holds p1 while scl_i=0 (slave clock stretching).
  - If the hold exceeds STRETCH_TIMEOUT cycles: release both lines, set ack_err=1, pulse done, return to IDLE.
- Undefined: scl_i is ignored; timing is fixed as above.

Test Plan:
- Write, addr=0x50, wdata=0xA5, slave ACKs:
  - SDA sampled at p2 reads 1010000_0 then 10100101.
  - done at cycle 80, ack_err=0, busy low the same cycle done pulses.
- Read, addr=0x3C, slave drives 0x5A:
  - rdata=0x5A at done, ack_err=0.
  - Master releases SDA during RD_ACK (NACK).
- Address NACK, addr=0x11 with sda_i held 1:
  - ack_err=1, no data phase, STOP follows, done at cycle 44.
- Second start pulsed at cycle 10 of a transaction, then again 2 cycles after done:
  - Both are ignored (busy, then bus-free window).
  - A start 4 cycles after done is accepted.
- Reset asserted mid-ADDR bit 3: next cycle sda_oe=0, scl_oe=0, busy=0, no done pulse.
- With I2C_MASTER_CLK_STRETCH_EN, scl_i held low 20 cycles at ADDR bit 0 p1:
  - Transaction completes 20 cycles late with correct data.
  - Holding scl_i low 300 cycles gives ack_err=1 and done, with lines released.
